// File: rtl/ram_if_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states, grant owner,
// RAM transfer size codes and the grant selection rule.
package ram_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // A lone request wins outright; on a conflict the requester that did not
  // win last time is served, so the two sides alternate under contention.
  function automatic grant_e pick_grant(input logic   if_req,
                                        input logic   d_req,
                                        input grant_e last);
    if (if_req && d_req) begin
      return (last == GNT_D) ? GNT_IF : GNT_D;
    end else if (if_req) begin
      return GNT_IF;
    end else begin
      return GNT_D;
    end
  endfunction

endpackage

// File: rtl/mfc_timeout_counter.sv
// Counts ACCESS cycles and flags the cycle on which the RAM has used up its
// full allowance of TIMEOUT cycles without answering.
module mfc_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The count equals the number of completed enabled cycles, so the
  // TIMEOUT-th enabled cycle is the one that sees LAST.
  assign expired_o = en_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and hold once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store.
// Latches the winning request, runs the MFA/MFC handshake with a timeout,
// captures read data and holds a level acknowledge until the request drops.
module ram_port_arbiter
  import ram_if_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddress,
  output logic              ifAck,
  output logic [DATA_W-1:0] ifData,
  input  logic              dReq,
  input  logic              dRW,
  input  logic [1:0]        dSize,
  input  logic [ADDR_W-1:0] dAddress,
  input  logic [DATA_W-1:0] dWrData,
  output logic              dAck,
  output logic [DATA_W-1:0] dRdData,
  output logic              busErr,
  output logic              ramMFA,
  output logic              ramRW,
  output logic [1:0]        ramDataSize,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramWrData,
  input  logic [DATA_W-1:0] ramRdData,
  input  logic              ramMFC
);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_q, last_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              bus_err_q, bus_err_d;
  logic              granted_req;
  logic              tmo_expired;
  grant_e            pick;

  mfc_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i     (Clk),
    .rst_i     (reset),
    .clr_i     (state_q != ST_ACCESS),
    .en_i      (state_q == ST_ACCESS),
    .expired_o (tmo_expired)
  );

  assign pick        = pick_grant(ifReq, dReq, last_q);
  assign granted_req = (grant_q == GNT_IF) ? ifReq : dReq;

  assign ramMFA      = (state_q == ST_ACCESS);
  assign ramRW       = rw_q;
  assign ramDataSize = size_q;
  assign ramAddress  = addr_q;
  assign ramWrData   = wdata_q;
  assign ifAck       = (state_q == ST_DONE) && (grant_q == GNT_IF);
  assign dAck        = (state_q == ST_DONE) && (grant_q == GNT_D);
  assign ifData      = if_data_q;
  assign dRdData     = d_data_q;
  assign busErr      = bus_err_q;

  // Next-state and register-load logic for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    rw_d      = rw_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    d_data_d  = d_data_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ifReq || dReq) begin
          grant_d = pick;
          last_d  = pick;
          state_d = ST_ACCESS;
          if (pick == GNT_IF) begin
            rw_d    = 1'b1;
            size_d  = SIZE_WORD;
            addr_d  = ifAddress;
            wdata_d = '0;
          end else begin
            rw_d    = dRW;
            size_d  = dSize;
            addr_d  = dAddress;
            wdata_d = dWrData;
          end
        end
      end
      ST_ACCESS: begin
        // A late MFC on the expiry cycle still counts as a good completion.
        if (ramMFC) begin
          bus_err_d = 1'b0;
          state_d   = ST_DONE;
          if (rw_q) begin
            if (grant_q == GNT_IF) begin
              if_data_d = ramRdData;
            end else begin
              d_data_d = ramRdData;
            end
          end
        end else if (tmo_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
          if (grant_q == GNT_IF) begin
            if_data_d = '0;
          end else begin
            d_data_d = '0;
          end
        end
      end
      ST_DONE: begin
        // Wait for both the requester and the RAM to release their lines.
        if (!granted_req && !ramMFC) begin
          bus_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and RAM-side/requester-side output registers.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_IF;
      last_q    <= GNT_D;
      rw_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      d_data_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      rw_q      <= rw_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      d_data_q  <= d_data_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule
